// File: rtl/state_loader.sv
// Serial row loader for the encoder: assembles 64 rows of 25 bits into one
// state, pulses start, then waits for the encoder to finish.
module state_loader #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROW_W-1:0]        in_row,
  input  logic                    in_first,
  output logic [ROWS*ROW_W-1:0]   raw_data,
  output logic                    start,
  input  logic                    enc_ready,
  output logic                    busy,
  output logic [15:0]             blk_cnt
);

  localparam int STATE_W = ROWS * ROW_W;
  localparam int CW      = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT
  } state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0][ROWS-1:0]      raw_q, raw_d;
  logic                            start_q, start_d;
  logic                            rdy_prev_q, rdy_prev_d;
  logic [15:0]                     blk_cnt_q, blk_cnt_d;
  logic [CW-1:0]                   wr_z;

  // Lane-major packing puts row z, lane j at bit ROWS*j + z.
  assign raw_data = STATE_W'(raw_q);
  assign start    = start_q;
  assign blk_cnt  = blk_cnt_q;
  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_LOAD);

  assign wr_z = in_first ? '0 : row_cnt_q;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    raw_d      = raw_q;
    start_d    = 1'b0;
    rdy_prev_d = enc_ready;
    blk_cnt_d  = blk_cnt_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          for (int j = 0; j < ROW_W; j++) begin
            raw_d[j][wr_z] = in_row[j];
          end
          if (in_first) begin
            row_cnt_d = CW'(1);
          end else if (row_cnt_q == CW'(ROWS - 1)) begin
            row_cnt_d = '0;
            state_d   = S_FIRE;
            start_d   = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + CW'(1);
          end
        end
      end
      S_FIRE: begin
        // Forget any Ready level left over from the previous block.
        rdy_prev_d = 1'b0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (!rdy_prev_q && enc_ready) begin
          state_d   = S_LOAD;
          blk_cnt_d = blk_cnt_q + 16'd1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD;
      row_cnt_q  <= '0;
      raw_q      <= '0;
      start_q    <= 1'b0;
      rdy_prev_q <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      raw_q      <= raw_d;
      start_q    <= start_d;
      rdy_prev_q <= rdy_prev_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_state_loader.sv
// Self-checking bench for state_loader: directed block sequences with random
// rows and gaps, compared against a row-array reference model.
module tb_state_loader;

  localparam int ROWS  = 64;
  localparam int ROW_W = 25;
  localparam int SW    = ROWS * ROW_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_row;
  logic              in_first;
  logic [SW-1:0]     raw_data;
  logic              start;
  logic              enc_ready;
  logic              busy;
  logic [15:0]       blk_cnt;

  state_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_first  (in_first),
    .raw_data  (raw_data),
    .start     (start),
    .enc_ready (enc_ready),
    .busy      (busy),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int start_cnt = 0;

  logic [ROW_W-1:0] mdl_rows [ROWS];
  int               mdl_idx;
  logic [15:0]      mdl_blk;

  always @(posedge clk) if (start === 1'b1) start_cnt++;

  function automatic logic [SW-1:0] expect_raw();
    logic [SW-1:0] r;
    r = '0;
    for (int z = 0; z < ROWS; z++)
      for (int j = 0; j < ROW_W; j++)
        r[ROWS*j + z] = mdl_rows[z][j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_raw(input string tag);
    logic [SW-1:0] e;
    int bad;
    e = expect_raw();
    n_chk++;
    assert (raw_data === e) else begin
      n_err++;
      bad = -1;
      for (int i = SW - 1; i >= 0; i--)
        if (raw_data[i] !== e[i]) bad = i;
      $error("FAIL %s observed bit%0d=%b expected=%b",
             tag, bad, raw_data[bad], e[bad]);
    end
  endtask

  task automatic mdl_reset();
    for (int z = 0; z < ROWS; z++) mdl_rows[z] = '0;
    mdl_idx = 0;
    mdl_blk = '0;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] row, input logic first,
                          input int gap, output logic fired);
    int t;
    if (gap > 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
    in_valid = 1'b1;
    in_row   = row;
    in_first = first;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    if (first) mdl_idx = 0;
    mdl_rows[mdl_idx] = row;
    mdl_idx++;
    fired = 1'b0;
    if (mdl_idx == ROWS) begin
      mdl_idx = 0;
      fired   = 1'b1;
    end
    chk("start_timing", 64'(start), 64'(fired));
  endtask

  task automatic send_block(input int mode, input int gap);
    logic f;
    logic [ROW_W-1:0] r;
    for (int z = 0; z < ROWS; z++) begin
      case (mode)
        0:       r = 25'h1 << (z % 25);
        1:       r = 25'h1FFFFFF;
        default: r = 25'($urandom);
      endcase
      send_row(r, z == 0, gap, f);
    end
  endtask

  // Entered at the FIRE cycle; source keeps pushing while the loader waits.
  task automatic finish_block(input int low_cycles);
    chk("fire_busy", 64'(busy), 64'd1);
    chk("fire_ready", 64'(in_ready), 64'd0);
    chk_raw("fire_raw");
    enc_ready = 1'b0;
    in_valid  = 1'b1;
    in_row    = 25'($urandom);
    repeat (low_cycles) begin
      @(negedge clk);
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_ready", 64'(in_ready), 64'd0);
      chk("wait_start", 64'(start), 64'd0);
    end
    chk_raw("wait_raw_hold");
    enc_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mdl_blk++;
    chk("exit_ready", 64'(in_ready), 64'd1);
    chk("exit_busy", 64'(busy), 64'd0);
    chk("blk_cnt", 64'(blk_cnt), 64'(mdl_blk));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_start"}, 64'(start), 64'd0);
    chk({tag, "_blk"}, 64'(blk_cnt), 64'd0);
    chk_raw({tag, "_raw"});
  endtask

  initial begin
    logic f;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_row    = '0;
    enc_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_reset("reset");

    start_cnt = 0;
    send_block(0, 0);
    finish_block(3);
    chk("t1_start_cnt", 64'(start_cnt), 64'd1);

    start_cnt = 0;
    send_block(0, 4);
    finish_block(3);
    chk("t2_start_cnt", 64'(start_cnt), 64'd1);

    start_cnt = 0;
    for (int z = 0; z < 30; z++) send_row(25'($urandom), z == 0, 1, f);
    send_block(1, 2);
    chk("t4_all_ones", 64'(&raw_data), 64'd1);
    finish_block(2);
    chk("t4_start_cnt", 64'(start_cnt), 64'd1);

    start_cnt = 0;
    for (int z = 0; z < ROWS - 1; z++) send_row(25'($urandom), z == 0, 0, f);
    send_row(25'($urandom), 1'b1, 0, f);
    chk("resync_no_start", 64'(busy), 64'd0);
    for (int z = 1; z < ROWS; z++) send_row(25'($urandom), 1'b0, 1, f);
    finish_block(1);
    chk("resync_start_cnt", 64'(start_cnt), 64'd1);

    for (int b = 0; b < 3; b++) begin
      start_cnt = 0;
      send_block(2, 3);
      finish_block(1 + b);
      chk("rand_start_cnt", 64'(start_cnt), 64'd1);
    end

    send_block(2, 0);
    enc_ready = 1'b0;
    @(negedge clk);
    do_reset("rst_wait");
    for (int z = 0; z < 40; z++) send_row(25'($urandom), z == 0, 1, f);
    do_reset("rst_load");
    start_cnt = 0;
    send_block(0, 0);
    finish_block(3);
    chk("t5_start_cnt", 64'(start_cnt), 64'd1);

    force dut.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    @(negedge clk);
    mdl_blk = 16'hFFFF;
    chk("preload_blk", 64'(blk_cnt), 64'hFFFF);
    send_block(2, 1);
    finish_block(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
